blink_rtc: RTL and testbench

//  Parametrised real-time-clock and timer-interrupt unit, the next generation of the BLINK RTC.

---
 rtl/blink_rtc.sv | 162 ++++++++++++++++
 tb/tb_blink_rtc.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_rtc.sv
// BLINK RTC: prescales mck into tick/second/minute counters, latches status
// events behind a write-one-to-clear register and mask, and serves snapshot reads.
module blink_rtc #(
    parameter int unsigned TICK_DIV  = 49152,
    parameter int unsigned TICKS_SEC = 200,
    parameter int unsigned SECS_MIN  = 60,
    parameter int unsigned MIN_W     = 21
) (
    input  logic       mck,
    input  logic       rin,
    input  logic       rtc_clr,
    input  logic [7:0] ca,
    input  logic       io_wr,
    input  logic       io_rd,
    input  logic [7:0] cdi,
    output logic [7:0] rdata,
    output logic       rd_hit,
    output logic [3:0] tsta,
    output logic       int_req
);

    localparam int unsigned TCK_W  = $clog2(TICK_DIV);
    localparam int unsigned TIM0_W = 8;
    localparam int unsigned TIM1_W = 6;
    localparam int unsigned STA_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SNAP_W = 24;

    localparam logic [TCK_W-1:0]  TCK_LAST  = TCK_W'(TICK_DIV - 1);
    localparam logic [TIM0_W-1:0] TIM0_LAST = TIM0_W'(TICKS_SEC - 1);
    localparam logic [TIM1_W-1:0] TIM1_LAST = TIM1_W'(SECS_MIN - 1);

    localparam logic [7:0] ADDR_ACK  = 8'hB4;
    localparam logic [7:0] ADDR_TMK  = 8'hB5;
    localparam logic [7:0] ADDR_TIM0 = 8'hD0;
    localparam logic [7:0] ADDR_TIM1 = 8'hD1;
    localparam logic [7:0] ADDR_MIN0 = 8'hD2;
    localparam logic [7:0] ADDR_MIN1 = 8'hD3;
    localparam logic [7:0] ADDR_MIN2 = 8'hD4;

    logic [TCK_W-1:0]  tck_q,     tck_d;
    logic [TIM0_W-1:0] tim0_q,    tim0_d;
    logic [TIM1_W-1:0] tim1_q,    tim1_d;
    logic [MIN_W-1:0]  timm_q,    timm_d;
    logic [TIM1_W-1:0] shd_sec_q, shd_sec_d;
    logic [MIN_W-1:0]  shd_min_q, shd_min_d;
    logic [STA_W-1:0]  tsta_q,    tsta_d;
    logic [STA_W-1:0]  tmk_q,     tmk_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic              rd_hit_q,  rd_hit_d;
    logic              int_req_q, int_req_d;

    logic              tick_c, sec_c, min_c, ovf_c;
    logic [STA_W-1:0]  ev_c;
    logic [STA_W-1:0]  ack_c;
    logic [SNAP_W-1:0] snap_min_c;
    logic              unused_cdi_c;

    // Event cascade: each stage fires only when the one below it wraps.
    assign tick_c = !rtc_clr && (tck_q == TCK_LAST);
    assign sec_c  = tick_c && (tim0_q == TIM0_LAST);
    assign min_c  = sec_c && (tim1_q == TIM1_LAST);
    assign ovf_c  = min_c && (&timm_q);
    assign ev_c   = {ovf_c, min_c, sec_c, tick_c};

    assign ack_c        = (io_wr && (ca == ADDR_ACK)) ? cdi[STA_W-1:0] : '0;
    assign snap_min_c   = SNAP_W'(shd_min_q);
    assign unused_cdi_c = ^cdi[DATA_W-1:STA_W];

    // Counter next state; a held clear freezes every stage at zero.
    always_comb begin
        tck_d  = tck_q;
        tim0_d = tim0_q;
        tim1_d = tim1_q;
        timm_d = timm_q;
        if (rtc_clr) begin
            tck_d  = '0;
            tim0_d = '0;
            tim1_d = '0;
            timm_d = '0;
        end else begin
            tck_d = tick_c ? '0 : tck_q + TCK_W'(1);
            if (tick_c) begin
                tim0_d = sec_c ? '0 : tim0_q + TIM0_W'(1);
            end
            if (sec_c) begin
                tim1_d = min_c ? '0 : tim1_q + TIM1_W'(1);
            end
            if (min_c) begin
                timm_d = timm_q + MIN_W'(1);
            end
        end
    end

    // Status latch: a same-edge event overrides its acknowledge.
    always_comb begin
        tsta_d    = (tsta_q & ~ack_c) | ev_c;
        tmk_d     = tmk_q;
        int_req_d = |(tsta_q & tmk_q);
        if (io_wr && (ca == ADDR_TMK)) begin
            tmk_d = cdi[STA_W-1:0];
        end
    end

    // Read decode; a D0 read freezes the upper counters for the following bytes.
    always_comb begin
        rdata_d   = rdata_q;
        rd_hit_d  = 1'b0;
        shd_sec_d = shd_sec_q;
        shd_min_d = shd_min_q;
        if (io_rd) begin
            rd_hit_d = 1'b1;
            case (ca)
                ADDR_TMK:  rdata_d = {4'b0000, tsta_q};
                ADDR_TIM0: begin
                    rdata_d   = tim0_q;
                    shd_sec_d = tim1_q;
                    shd_min_d = timm_q;
                end
                ADDR_TIM1: rdata_d = {2'b00, shd_sec_q};
                ADDR_MIN0: rdata_d = snap_min_c[7:0];
                ADDR_MIN1: rdata_d = snap_min_c[15:8];
                ADDR_MIN2: rdata_d = snap_min_c[23:16];
                default:   rd_hit_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            tck_q     <= '0;
            tim0_q    <= '0;
            tim1_q    <= '0;
            timm_q    <= '0;
            shd_sec_q <= '0;
            shd_min_q <= '0;
            tsta_q    <= '0;
            tmk_q     <= '0;
            rdata_q   <= '0;
            rd_hit_q  <= 1'b0;
            int_req_q <= 1'b0;
        end else begin
            tck_q     <= tck_d;
            tim0_q    <= tim0_d;
            tim1_q    <= tim1_d;
            timm_q    <= timm_d;
            shd_sec_q <= shd_sec_d;
            shd_min_q <= shd_min_d;
            tsta_q    <= tsta_d;
            tmk_q     <= tmk_d;
            rdata_q   <= rdata_d;
            rd_hit_q  <= rd_hit_d;
            int_req_q <= int_req_d;
        end
    end

    assign rdata   = rdata_q;
    assign rd_hit  = rd_hit_q;
    assign tsta    = tsta_q;
    assign int_req = int_req_q;

endmodule

// File: tb/tb_blink_rtc.sv
// Bench for blink_rtc: elapsed-cycle arithmetic model of the RTC, directed
// scenarios plus randomized register traffic.
module tb_blink_rtc;

    localparam int TD = 4;
    localparam int TS = 3;
    localparam int SM = 2;
    localparam int MW = 4;

    localparam logic [7:0] A_ACK = 8'hB4;
    localparam logic [7:0] A_TMK = 8'hB5;
    localparam logic [7:0] A_T0  = 8'hD0;
    localparam logic [7:0] A_T1  = 8'hD1;
    localparam logic [7:0] A_M0  = 8'hD2;
    localparam logic [7:0] A_M1  = 8'hD3;
    localparam logic [7:0] A_M2  = 8'hD4;

    logic       mck = 1'b0;
    logic       rin;
    logic       rtc_clr;
    logic [7:0] ca;
    logic       io_wr;
    logic       io_rd;
    logic [7:0] cdi;
    logic [7:0] rdata;
    logic       rd_hit;
    logic [3:0] tsta;
    logic       int_req;

    int vectors = 0;
    int errs    = 0;

    // Model: m_n counts edges since reset/clear; counters are derived from it.
    int         m_n;
    int         m_shd_sec;
    int         m_shd_min;
    logic [3:0] m_tsta;
    logic [3:0] m_tmk;
    logic [7:0] m_rdata;
    logic       m_hit;
    logic       m_int;

    blink_rtc #(
        .TICK_DIV (TD),
        .TICKS_SEC(TS),
        .SECS_MIN (SM),
        .MIN_W    (MW)
    ) dut (
        .mck    (mck),
        .rin    (rin),
        .rtc_clr(rtc_clr),
        .ca     (ca),
        .io_wr  (io_wr),
        .io_rd  (io_rd),
        .cdi    (cdi),
        .rdata  (rdata),
        .rd_hit (rd_hit),
        .tsta   (tsta),
        .int_req(int_req)
    );

    always #5 mck = ~mck;

    function automatic int f_tim0(input int n); return (n / TD) % TS; endfunction
    function automatic int f_tim1(input int n); return (n / (TD * TS)) % SM; endfunction
    function automatic int f_timm(input int n); return (n / (TD * TS * SM)) % (1 << MW); endfunction

    function automatic logic [13:0] dut_v();
        return {rdata, rd_hit, tsta, int_req};
    endfunction

    function automatic logic [13:0] model_v();
        return {m_rdata, m_hit, m_tsta, m_int};
    endfunction

    task automatic model_reset();
        m_n = 0; m_shd_sec = 0; m_shd_min = 0;
        m_tsta = 4'h0; m_tmk = 4'h0; m_rdata = 8'h00; m_hit = 1'b0; m_int = 1'b0;
    endtask

    task automatic apply_reset();
        rin = 1'b1; io_rd = 1'b0; io_wr = 1'b0; rtc_clr = 1'b0; ca = 8'h00; cdi = 8'h00;
        repeat (2) @(negedge mck);
        model_reset();
        rin = 1'b0;
    endtask

    task automatic cycle(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input logic clr);
        int         nn;
        logic [3:0] ev;
        logic [3:0] ack;
        logic       nxt_int;
        io_rd = rd; io_wr = wr; ca = a; cdi = d; rtc_clr = clr;
        @(posedge mck);
        ev = 4'h0;
        nn = clr ? 0 : m_n + 1;
        if (!clr) begin
            ev[0] = ((nn % TD) == 0);
            ev[1] = ((nn % (TD * TS)) == 0);
            ev[2] = ((nn % (TD * TS * SM)) == 0);
            ev[3] = ((nn % (TD * TS * SM * (1 << MW))) == 0);
        end
        ack     = (wr && a == A_ACK) ? d[3:0] : 4'h0;
        nxt_int = |(m_tsta & m_tmk);
        m_hit   = 1'b0;
        if (rd) begin
            m_hit = 1'b1;
            if (a == A_TMK) m_rdata = {4'h0, m_tsta};
            else if (a == A_T0) begin
                m_rdata   = 8'(f_tim0(m_n));
                m_shd_sec = f_tim1(m_n);
                m_shd_min = f_timm(m_n);
            end
            else if (a == A_T1) m_rdata = 8'(m_shd_sec);
            else if (a == A_M0) m_rdata = 8'(m_shd_min);
            else if (a == A_M1) m_rdata = 8'(m_shd_min >> 8);
            else if (a == A_M2) m_rdata = 8'(m_shd_min >> 16);
            else m_hit = 1'b0;
        end
        m_tsta = (m_tsta & ~ack) | ev;
        if (wr && a == A_TMK) m_tmk = d[3:0];
        m_int = nxt_int;
        m_n   = nn;
        #1;
        io_rd = 1'b0; io_wr = 1'b0;
    endtask

    task automatic idle(input logic clr);      cycle(1'b0, 1'b0, 8'h00, 8'h00, clr); endtask
    task automatic rd(input logic [7:0] a);    cycle(1'b1, 1'b0, a, 8'h00, 1'b0);    endtask
    task automatic wr(input logic [7:0] a, input logic [7:0] d); cycle(1'b0, 1'b1, a, d, 1'b0); endtask

    task automatic test_reset();
        rin = 1'b1; io_rd = 1'b0; io_wr = 1'b0; rtc_clr = 1'b0; ca = 8'h00; cdi = 8'h00;
        repeat (2) @(negedge mck);
        model_reset();
        vectors++;
        if (dut_v() !== 14'h0) begin
            errs++; $display("FAIL reset_outputs got=%h want=%h", dut_v(), 14'h0);
        end
        rin = 1'b0;
        idle(1'b0);
        vectors++;
        if (dut_v() !== model_v()) begin
            errs++; $display("FAIL reset_first_cycle got=%h want=%h", dut_v(), model_v());
        end
    endtask

    task automatic test_free_run();
        int   idx;
        logic want;
        logic chk;
        apply_reset();
        for (int c = 1; c <= 384; c++) begin
            if (c == 25) rd(A_T0);
            else if (c == 26) rd(A_M0);
            else idle(1'b0);
            vectors++;
            if (dut_v() !== model_v()) begin
                errs++; $display("FAIL free_run c=%0d got=%h want=%h", c, dut_v(), model_v());
            end
            chk = 1'b1; idx = 0; want = 1'b0;
            case (c)
                3:   begin idx = 0; want = 1'b0; end
                4:   begin idx = 0; want = 1'b1; end
                11:  begin idx = 1; want = 1'b0; end
                12:  begin idx = 1; want = 1'b1; end
                23:  begin idx = 2; want = 1'b0; end
                24:  begin idx = 2; want = 1'b1; end
                383: begin idx = 3; want = 1'b0; end
                384: begin idx = 3; want = 1'b1; end
                default: chk = 1'b0;
            endcase
            if (chk) begin
                vectors++;
                if (tsta[idx] !== want) begin
                    errs++; $display("FAIL free_run_tsta%0d c=%0d got=%b want=%b", idx, c, tsta[idx], want);
                end
            end
            if (c == 26) begin
                vectors++;
                if (rdata !== 8'h01) begin
                    errs++; $display("FAIL free_run_timm c=%0d got=%h want=01", c, rdata);
                end
            end
        end
    endtask

    task automatic test_irq();
        int k;
        apply_reset();
        wr(A_TMK, 8'h01);
        for (k = 0; k < 20 && tsta[0] !== 1'b1; k++) idle(1'b0);
        vectors++;
        if (tsta[0] !== 1'b1) begin
            errs++; $display("FAIL irq_tick_timeout got=%b want=1", tsta[0]);
        end
        idle(1'b0);
        vectors++;
        if (int_req !== 1'b1 || dut_v() !== model_v()) begin
            errs++; $display("FAIL irq_raise got=%h want=%h", dut_v(), model_v());
        end
        wr(A_ACK, 8'h01);
        vectors++;
        if (tsta[0] !== 1'b0 || dut_v() !== model_v()) begin
            errs++; $display("FAIL irq_ack got=%h want=%h", dut_v(), model_v());
        end
        wr(A_ACK, 8'h0E);
        vectors++;
        if (tsta !== 4'h0 || int_req !== 1'b0 || dut_v() !== model_v()) begin
            errs++; $display("FAIL irq_drop_noop_ack got=%h want=%h", dut_v(), model_v());
        end
    endtask

    task automatic test_ack_collision();
        int k;
        apply_reset();
        for (k = 0; k < 20 && tsta[0] !== 1'b1; k++) idle(1'b0);
        for (k = 0; k < 20 && ((m_n + 1) % TD) != 0; k++) idle(1'b0);
        wr(A_ACK, 8'h01);
        vectors++;
        if (tsta[0] !== 1'b1 || dut_v() !== model_v()) begin
            errs++; $display("FAIL ack_collision got=%h want=%h", dut_v(), model_v());
        end
    endtask

    task automatic test_atomic_read();
        logic [7:0] addrs [6];
        logic [7:0] want  [6];
        logic       whit  [6];
        int k;
        addrs = '{A_T1, A_M1, A_M2, A_M0, 8'h77, A_TMK};
        want  = '{8'h01, 8'h00, 8'h00, 8'h03, 8'h03, 8'h00};
        whit  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        apply_reset();
        for (k = 0; k < 200 && m_n != 92; k++) idle(1'b0);
        rd(A_T0);
        vectors++;
        if (rdata !== 8'h02 || rd_hit !== 1'b1) begin
            errs++; $display("FAIL atomic_d0 got=%h/%b want=02/1", rdata, rd_hit);
        end
        repeat (12) idle(1'b0);
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i]);
            if (i == 5) want[i] = m_rdata;
            vectors++;
            if (rdata !== want[i] || rd_hit !== whit[i] || dut_v() !== model_v()) begin
                errs++; $display("FAIL atomic_rd_%h got=%h/%b want=%h/%b", addrs[i], rdata, rd_hit, want[i], whit[i]);
            end
        end
    endtask

    task automatic test_clear();
        apply_reset();
        wr(A_TMK, 8'h0F);
        repeat (6) idle(1'b0);
        idle(1'b1);
        cycle(1'b0, 1'b1, A_ACK, 8'h0F, 1'b1);
        for (int c = 3; c <= 50; c++) begin
            cycle((c % 10) == 0, 1'b0, A_T0, 8'h00, 1'b1);
            vectors++;
            if (tsta !== 4'h0 || ((c % 10) == 0 && rdata !== 8'h00) || dut_v() !== model_v()) begin
                errs++; $display("FAIL clear_hold c=%0d got=%h want=%h", c, dut_v(), model_v());
            end
        end
        for (int c = 1; c <= 5; c++) begin
            idle(1'b0);
            vectors++;
            if ((c < 4 && tsta[0] !== 1'b0) || (c >= 4 && tsta[0] !== 1'b1) ||
                (c == 5 && int_req !== 1'b1) || dut_v() !== model_v()) begin
                errs++; $display("FAIL clear_release c=%0d got=%h want=%h", c, dut_v(), model_v());
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] addrs [8];
        int         sel;
        logic [7:0] a;
        logic       r, w, clr;
        addrs = '{A_ACK, A_TMK, A_T0, A_T1, A_M0, A_M1, A_M2, 8'h00};
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            sel = int'($urandom_range(7, 0));
            a   = (sel == 7) ? 8'($urandom) : addrs[sel];
            r   = ($urandom_range(99, 0) < 30);
            w   = !r && ($urandom_range(99, 0) < 25);
            clr = ($urandom_range(299, 0) == 0);
            cycle(r, w, a, 8'($urandom), clr);
            vectors++;
            if (dut_v() !== model_v()) begin
                errs++; $display("FAIL random i=%0d a=%h got=%h want=%h", i, a, dut_v(), model_v());
            end
        end
    endtask

    task automatic test_async_reset();
        int k;
        apply_reset();
        wr(A_TMK, 8'h0F);
        for (k = 0; k < 500 && !(tsta == 4'hF && int_req == 1'b1); k++) idle(1'b0);
        vectors++;
        if (tsta !== 4'hF || int_req !== 1'b1) begin
            errs++; $display("FAIL async_setup_timeout got=%h/%b want=f/1", tsta, int_req);
        end
        rd(A_TMK);
        #2;
        rin = 1'b1;
        #1;
        vectors++;
        if (dut_v() !== 14'h0) begin
            errs++; $display("FAIL async_reset got=%h want=%h", dut_v(), 14'h0);
        end
        model_reset();
        @(negedge mck);
        rin = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        rin = 1'b1; rtc_clr = 1'b0; io_rd = 1'b0; io_wr = 1'b0; ca = 8'h00; cdi = 8'h00;
        model_reset();
        test_reset();
        test_free_run();
        test_irq();
        test_ack_collision();
        test_atomic_read();
        test_clear();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
